tdp_ram_36k: RTL and testbench
==============================

# tdp_ram_36k

True dual-port 36 Kb block RAM, organised as 1024 words of 36 bits (four 9-bit lanes, each 8 data bits plus 1 parity bit). Two independent read/write ports, A and B, share one clock. Each port has its own configurable width of 9, 18 or 36 bits. The block is the storage primitive under the FIFO and general memory-mapped users.

## Interface
Parameters:
- INIT, default all-zero (32768 bits): initial data contents; bit 32·w+8·i+b is data bit b of lane i of word w.
- INIT_PARITY, default all-zero (4096 bits): initial parity; bit 4·w+i is the parity of lane i of word w. Narrower overrides are zero-extended.
- WRITE_WIDTH_A, default 36: port A write width (9, 18, 36).
- READ_WIDTH_A, default 36: port A read width (9, 18, 36).
- WRITE_WIDTH_B, default 36: port B write width (9, 18, 36).
- READ_WIDTH_B, default 36: port B read width (9, 18, 36).

Ports (one clock; reset is synchronous and active-low):
- CLK  in  1  single clock for both ports, rising edge.
- RESET_N  in  1  synchronous active-low reset of the read registers.
- WEN_A, WEN_B  in  1  write enable per port.
- REN_A, REN_B  in  1  read enable per port.
- BE_A, BE_B  in  4  lane write enables.
- ADDR_A, ADDR_B  in  15  byte-lane address, MSB-aligned.
- WDATA_A, WDATA_B  in  32  write data.
- WPARITY_A, WPARITY_B  in  4  write parity.
- RDATA_A, RDATA_B  out  32  registered read data.
- RPARITY_A, RPARITY_B  out  4  registered read parity.

## Operation
- Word address is ADDR[14:5]. Lane 0 is the least significant lane.
- Width 36 port:
  - All four lanes.
  - Lane i is {PARITY[i], DATA[8i+7:8i]}.
  - BE[i] gates the write of lane i.
- Width 18 port:
  - Half select ADDR[4]; half h uses lanes 2h and 2h+1.
  - Write uses WDATA[15:0] and WPARITY[1:0], gated by BE[1:0].
  - Read returns RDATA[15:0] and RPARITY[1:0]; upper bits are 0.
- Width 9 port:
  - Lane select ADDR[4:3].
  - Write uses WDATA[7:0] and WPARITY[0], gated by BE[0].
  - Read returns RDATA[7:0] and RPARITY[0]; upper bits are 0.
- Lower address bits below the selected granularity are ignored.
- A port's write width and read width are decoded independently, using the same ADDR.
- WEN and REN both high on one port: the write is performed; the read returns the pre-write (old) contents.
- Cross-port read of a lane being written in the same cycle returns the old contents.
- Both ports writing the same lane in the same cycle: port A's data is stored.
- Reset:
  - RDATA_x and RPARITY_x clear to 0.
  - Memory contents are untouched.
  - Reset overrides REN.
- Invalid width parameter: $fatal at elaboration, with the instance name and the offending value.

## Timing
- Write: committed at the CLK edge where WEN=1; visible to reads issued on the next cycle.
- Read latency is 1 cycle: REN sampled at edge n gives data on the outputs after edge n.
- Outputs hold their last value while REN=0.
- Reset value of every output is 0, applied at the first edge with RESET_N=0.
- No wrap logic: address decode is purely combinational from ADDR.

## Configuration
- TDP_RAM_COLLISION_WARN_EN defined:
  - Both ports write the same word and at least one common lane in one cycle: a $display warning naming the instance, the word address and the simulation time.
  - A read-during-write cross-port collision produces the same warning.
- Macro undefined: no checking; the data behaviour is unchanged.

## Structure
- Package tdp_ram_pkg holds:
  - Constants: DEPTH=1024, LANES=4, LANE_W=9, ADDR_W=15.
  - A width-to-lane-count function: 9→1, 18→2, 36→4.
  - A function that builds the lane mask from width, ADDR and BE.
- Sub-module tdp_ram_port, instantiated twice:
  - Lane decode and write-data steering into 4×9-bit lanes.
  - Read mux and output register.
- Storage is a single 1024×36 array in the top level.

## Test plan
- Init and reset:
  - INIT word 0 = 32'hDEADBEEF, parity 4'hA.
  - Reset low 2 cycles → RDATA_B=0.
  - Then REN_B at ADDR 0, width 36 → RDATA_B=32'hDEADBEEF, RPARITY_B=4'hA one cycle later.
- Width 36 round trip: WEN_A, ADDR=15'h0020 (word 1), WDATA=32'h12345678, WPARITY=4'h5, BE=4'hF → next-cycle REN_B returns the same values.
- Byte enables: write 32'hFFFFFFFF, then write 32'h00000000 with BE=4'b0101 to the same word → read 32'hFF00FF00.
- Width 9:
  - Write 9'h1AB, i.e. WDATA[7:0]=8'hAB and WPARITY[0]=1, at ADDR=15'h0018 (word 0, lane 3).
  - Read at width 9 → RDATA=8'hAB, RPARITY=1.
  - Read at width 36 → RDATA[31:24]=8'hAB, RPARITY[3]=1.
- Collisions:
  - Port A writes 32'h1 while port B writes 32'h2 to word 5 → a subsequent read gives 32'h1.
  - Same-cycle cross-port read of word 5 returns the prior value.
- Reset mid-operation: RESET_N low while REN_B=1 → RDATA_B=0 that cycle; memory still returns the stored data afterwards.

Source files
------------

// File: rtl/tdp_ram_pkg.sv
// Shared constants and lane-decode helpers for the 36 Kb true dual-port RAM.
package tdp_ram_pkg;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LANES   = 4;
  localparam int unsigned LANE_W  = 9;
  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned WORD_AW = 10;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned WORD_W  = LANES * LANE_W;

  typedef logic [DEPTH-1:0][WORD_W-1:0] mem_t;

  // Port width in bits to number of 9-bit lanes; 0 flags an unsupported width.
  function automatic int unsigned width_lanes(input int unsigned width);
    case (width)
      9:       return 1;
      18:      return 2;
      36:      return 4;
      default: return 0;
    endcase
  endfunction

  // Lanes of the addressed word touched by an access of the given width.
  function automatic logic [LANES-1:0] lane_mask(input int unsigned width,
                                                 input logic [ADDR_W-1:0] addr,
                                                 input logic [LANES-1:0] be);
    logic [LANES-1:0] m;
    m = '0;
    case (width)
      9:  m[addr[4:3]] = be[0];
      18: begin
        m[{addr[4], 1'b0}] = be[0];
        m[{addr[4], 1'b1}] = be[1];
      end
      default: m = be;
    endcase
    return m;
  endfunction

  // Packs the flat INIT/INIT_PARITY vectors into {parity, data} lanes per word.
  function automatic mem_t init_mem(input logic [DEPTH*DATA_W-1:0] d,
                                    input logic [DEPTH*LANES-1:0] p);
    mem_t m;
    m = '0;
    for (int unsigned w = 0; w < DEPTH; w++) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        m[w][i*LANE_W +: LANE_W] = {p[w*LANES+i], d[w*DATA_W+i*8 +: 8]};
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/tdp_ram_port.sv
// One RAM port: lane decode, write-data steering, read mux and output register.
module tdp_ram_port
  import tdp_ram_pkg::*;
#(
  parameter int unsigned WRITE_WIDTH = 36,
  parameter int unsigned READ_WIDTH  = 36
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wen,
  input  logic                ren,
  input  logic [LANES-1:0]    be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [LANES-1:0]    wparity,
  input  logic [WORD_W-1:0]   rword,
  output logic [WORD_AW-1:0]  word_addr_c,
  output logic [LANES-1:0]    wmask_c,
  output logic [LANES-1:0]    rmask_c,
  output logic [WORD_W-1:0]   wword_c,
  output logic [DATA_W-1:0]   rdata,
  output logic [LANES-1:0]    rparity
);

  localparam int unsigned WR_LANES = width_lanes(WRITE_WIDTH);
  localparam int unsigned RD_LANES = width_lanes(READ_WIDTH);
  localparam int unsigned WR_N     = (WR_LANES == 0) ? 1 : WR_LANES;
  localparam int unsigned RD_N     = (RD_LANES == 0) ? 1 : RD_LANES;

  if (WR_LANES == 0 || RD_LANES == 0) begin : g_bad_width
    $fatal(1, "%m: unsupported port width (write=%0d read=%0d)", WRITE_WIDTH, READ_WIDTH);
  end

  logic [1:0]        rbase;
  logic [1:0]        ridx;
  logic [DATA_W-1:0] rdata_nxt;
  logic [LANES-1:0]  rparity_nxt;
  logic              unused_addr;

  assign unused_addr = ^addr[2:0];

  assign word_addr_c = addr[ADDR_W-1 -: WORD_AW];
  assign wmask_c     = wen ? lane_mask(WRITE_WIDTH, addr, be) : '0;
  assign rmask_c     = ren ? lane_mask(READ_WIDTH, addr, '1) : '0;

  // Narrow writes replicate the low source lanes across the word; the mask picks the target.
  always_comb begin
    wword_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      wword_c[i*LANE_W +: LANE_W] = {wparity[i % WR_N], wdata[(i % WR_N)*8 +: 8]};
    end
  end

  // Selected lanes land at the bottom of the read bus; unused upper lanes read 0.
  always_comb begin
    rdata_nxt   = '0;
    rparity_nxt = '0;
    ridx        = '0;
    rbase       = (RD_N == 1) ? addr[4:3] : (RD_N == 2) ? {addr[4], 1'b0} : 2'b00;
    for (int unsigned j = 0; j < RD_N; j++) begin
      ridx = rbase + 2'(j);
      {rparity_nxt[j], rdata_nxt[j*8 +: 8]} = rword[32'(ridx)*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata   <= '0;
      rparity <= '0;
    end else if (ren) begin
      rdata   <= rdata_nxt;
      rparity <= rparity_nxt;
    end
  end

endmodule

// File: rtl/tdp_ram_36k.sv
// 1024x36 true dual-port block RAM with per-port 9/18/36-bit widths.
// Optional collision warnings: define TDP_RAM_COLLISION_WARN_EN.
module tdp_ram_36k
  import tdp_ram_pkg::*;
#(
  parameter logic [DEPTH*DATA_W-1:0] INIT        = '0,
  parameter logic [DEPTH*LANES-1:0]  INIT_PARITY = '0,
  parameter int unsigned WRITE_WIDTH_A = 36,
  parameter int unsigned READ_WIDTH_A  = 36,
  parameter int unsigned WRITE_WIDTH_B = 36,
  parameter int unsigned READ_WIDTH_B  = 36
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              WEN_A,
  input  logic              WEN_B,
  input  logic              REN_A,
  input  logic              REN_B,
  input  logic [LANES-1:0]  BE_A,
  input  logic [LANES-1:0]  BE_B,
  input  logic [ADDR_W-1:0] ADDR_A,
  input  logic [ADDR_W-1:0] ADDR_B,
  input  logic [DATA_W-1:0] WDATA_A,
  input  logic [DATA_W-1:0] WDATA_B,
  input  logic [LANES-1:0]  WPARITY_A,
  input  logic [LANES-1:0]  WPARITY_B,
  output logic [DATA_W-1:0] RDATA_A,
  output logic [DATA_W-1:0] RDATA_B,
  output logic [LANES-1:0]  RPARITY_A,
  output logic [LANES-1:0]  RPARITY_B
);

  mem_t mem = init_mem(INIT, INIT_PARITY);

  logic [WORD_AW-1:0] word_a, word_b;
  logic [LANES-1:0]   wmask_a, wmask_b, rmask_a, rmask_b;
  logic [WORD_W-1:0]  wword_a, wword_b;

  tdp_ram_port #(.WRITE_WIDTH(WRITE_WIDTH_A), .READ_WIDTH(READ_WIDTH_A)) u_port_a (
    .clk(CLK), .rst_n(RESET_N), .wen(WEN_A), .ren(REN_A), .be(BE_A), .addr(ADDR_A),
    .wdata(WDATA_A), .wparity(WPARITY_A), .rword(mem[word_a]),
    .word_addr_c(word_a), .wmask_c(wmask_a), .rmask_c(rmask_a), .wword_c(wword_a),
    .rdata(RDATA_A), .rparity(RPARITY_A)
  );

  tdp_ram_port #(.WRITE_WIDTH(WRITE_WIDTH_B), .READ_WIDTH(READ_WIDTH_B)) u_port_b (
    .clk(CLK), .rst_n(RESET_N), .wen(WEN_B), .ren(REN_B), .be(BE_B), .addr(ADDR_B),
    .wdata(WDATA_B), .wparity(WPARITY_B), .rword(mem[word_b]),
    .word_addr_c(word_b), .wmask_c(wmask_b), .rmask_c(rmask_b), .wword_c(wword_b),
    .rdata(RDATA_B), .rparity(RPARITY_B)
  );

  // Port A is applied last so it wins a same-lane write collision.
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (wmask_b[i]) mem[word_b][i*LANE_W +: LANE_W] <= wword_b[i*LANE_W +: LANE_W];
      if (wmask_a[i]) mem[word_a][i*LANE_W +: LANE_W] <= wword_a[i*LANE_W +: LANE_W];
    end
  end

`ifdef TDP_RAM_COLLISION_WARN_EN
  always @(posedge CLK) begin
    if (word_a == word_b) begin
      if (|(wmask_a & wmask_b))
        $display("%m: write-write collision at word %0d, time %0t", word_a, $time);
      else if (|(wmask_a & rmask_b) || |(wmask_b & rmask_a))
        $display("%m: read-during-write collision at word %0d, time %0t", word_a, $time);
    end
  end
`else
  logic unused_rmask;
  assign unused_rmask = ^{rmask_a, rmask_b};
`endif

endmodule

// File: tb/tb_tdp_ram_36k.sv
// Directed scoreboard bench for tdp_ram_36k: a 36/36 instance and a 9/18-width instance.
module tb_tdp_ram_36k;

  localparam logic [32767:0] TB_INIT   = 32768'(32'hDEADBEEF);
  localparam logic [4095:0]  TB_INIT_P = 4096'(4'hA);

  typedef struct {
    int          ch;
    string       tag;
    logic [35:0] val;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  logic CLK = 1'b0;
  logic RESET_N;

  // d_*: all ports 36 bits wide, preloaded
  logic        d_wen_a, d_wen_b, d_ren_a, d_ren_b;
  logic [3:0]  d_be_a, d_be_b, d_wpar_a, d_wpar_b, d_rpar_a, d_rpar_b;
  logic [14:0] d_addr_a, d_addr_b;
  logic [31:0] d_wdata_a, d_wdata_b, d_rdata_a, d_rdata_b;

  // n_*: port A 9/9, port B write 18 / read 36
  logic        n_wen_a, n_wen_b, n_ren_a, n_ren_b;
  logic [3:0]  n_be_a, n_be_b, n_wpar_a, n_wpar_b, n_rpar_a, n_rpar_b;
  logic [14:0] n_addr_a, n_addr_b;
  logic [31:0] n_wdata_a, n_wdata_b, n_rdata_a, n_rdata_b;

  always #5 CLK = ~CLK;

  tdp_ram_36k #(.INIT(TB_INIT), .INIT_PARITY(TB_INIT_P)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .WEN_A(d_wen_a), .WEN_B(d_wen_b), .REN_A(d_ren_a), .REN_B(d_ren_b),
    .BE_A(d_be_a), .BE_B(d_be_b), .ADDR_A(d_addr_a), .ADDR_B(d_addr_b),
    .WDATA_A(d_wdata_a), .WDATA_B(d_wdata_b), .WPARITY_A(d_wpar_a), .WPARITY_B(d_wpar_b),
    .RDATA_A(d_rdata_a), .RDATA_B(d_rdata_b), .RPARITY_A(d_rpar_a), .RPARITY_B(d_rpar_b)
  );

  tdp_ram_36k #(.WRITE_WIDTH_A(9), .READ_WIDTH_A(9), .WRITE_WIDTH_B(18), .READ_WIDTH_B(36)) u_nar (
    .CLK(CLK), .RESET_N(RESET_N),
    .WEN_A(n_wen_a), .WEN_B(n_wen_b), .REN_A(n_ren_a), .REN_B(n_ren_b),
    .BE_A(n_be_a), .BE_B(n_be_b), .ADDR_A(n_addr_a), .ADDR_B(n_addr_b),
    .WDATA_A(n_wdata_a), .WDATA_B(n_wdata_b), .WPARITY_A(n_wpar_a), .WPARITY_B(n_wpar_b),
    .RDATA_A(n_rdata_a), .RDATA_B(n_rdata_b), .RPARITY_A(n_rpar_a), .RPARITY_B(n_rpar_b)
  );

  task automatic push(input int ch, input string tag, input logic [35:0] val);
    exp_t e;
    e.ch = ch; e.tag = tag; e.val = val;
    q.push_back(e);
  endtask

  task automatic idle();
    d_wen_a = 0; d_wen_b = 0; d_ren_a = 0; d_ren_b = 0; d_be_a = '0; d_be_b = '0;
    n_wen_a = 0; n_wen_b = 0; n_ren_a = 0; n_ren_b = 0; n_be_a = '0; n_be_b = '0;
  endtask

  // Advance one edge, then drain the scoreboard against the registered outputs.
  task automatic step();
    exp_t e;
    logic [35:0] obs;
    @(posedge CLK);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.ch)
        0:       obs = {d_rpar_a, d_rdata_a};
        1:       obs = {d_rpar_b, d_rdata_b};
        2:       obs = {n_rpar_a, n_rdata_a};
        default: obs = {n_rpar_b, n_rdata_b};
      endcase
      total++;
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
    idle();
  endtask

  initial begin
    RESET_N = 0;
    idle();
    d_addr_a = '0; d_addr_b = '0; d_wdata_a = '0; d_wdata_b = '0; d_wpar_a = '0; d_wpar_b = '0;
    n_addr_a = '0; n_addr_b = '0; n_wdata_a = '0; n_wdata_b = '0; n_wpar_a = '0; n_wpar_b = '0;

    // reset for two cycles
    step();
    push(0, "rst_d_a", 36'h0); push(1, "rst_d_b", 36'h0);
    push(2, "rst_n_a", 36'h0); push(3, "rst_n_b", 36'h0);
    step();

    // init contents of word 0
    RESET_N = 1;
    d_ren_b = 1; d_addr_b = 15'h0000;
    push(1, "init_w0", {4'hA, 32'hDEADBEEF});
    step();
    push(1, "hold_b", {4'hA, 32'hDEADBEEF});
    step();

    // width-36 round trip on word 1
    d_wen_a = 1; d_addr_a = 15'h0020; d_wdata_a = 32'h12345678; d_wpar_a = 4'h5; d_be_a = 4'hF;
    step();
    d_ren_b = 1; d_addr_b = 15'h0020;
    push(1, "rt36", {4'h5, 32'h12345678});
    step();

    // same-port read during write returns old data
    d_wen_a = 1; d_ren_a = 1; d_addr_a = 15'h0020; d_wdata_a = 32'hAAAA5555; d_wpar_a = 4'h3; d_be_a = 4'hF;
    push(0, "rdw_old", {4'h5, 32'h12345678});
    step();
    d_ren_b = 1; d_addr_b = 15'h0020;
    push(1, "rdw_new", {4'h3, 32'hAAAA5555});
    step();

    // byte enables on word 3
    d_wen_a = 1; d_addr_a = 15'h0060; d_wdata_a = 32'hFFFFFFFF; d_wpar_a = 4'hF; d_be_a = 4'hF;
    step();
    d_wen_a = 1; d_addr_a = 15'h0060; d_wdata_a = 32'h00000000; d_wpar_a = 4'h0; d_be_a = 4'b0101;
    step();
    d_ren_a = 1; d_addr_a = 15'h0060;
    push(0, "be_mask", {4'hA, 32'hFF00FF00});
    step();

    // write-write collision on word 5: port A wins
    d_wen_a = 1; d_addr_a = 15'h00A0; d_wdata_a = 32'h1; d_wpar_a = 4'h1; d_be_a = 4'hF;
    d_wen_b = 1; d_addr_b = 15'h00A0; d_wdata_b = 32'h2; d_wpar_b = 4'h2; d_be_b = 4'hF;
    step();
    d_ren_b = 1; d_addr_b = 15'h00A0;
    push(1, "ww_a_wins", {4'h1, 32'h1});
    step();

    // cross-port read during write returns old data
    d_wen_a = 1; d_addr_a = 15'h00A0; d_wdata_a = 32'h77; d_wpar_a = 4'h0; d_be_a = 4'hF;
    d_ren_b = 1; d_addr_b = 15'h00A0;
    push(1, "xrdw_old", {4'h1, 32'h1});
    step();

    // reset overrides REN; memory kept
    RESET_N = 0;
    d_ren_b = 1; d_addr_b = 15'h00A0; d_ren_a = 1; d_addr_a = 15'h0060;
    push(1, "rst_mid_b", 36'h0); push(0, "rst_mid_a", 36'h0);
    step();
    RESET_N = 1;
    d_ren_b = 1; d_addr_b = 15'h00A0;
    push(1, "post_rst", {4'h0, 32'h77});
    step();

    // width-9 write of 9'h1AB into word 0 lane 3
    n_wen_a = 1; n_addr_a = 15'h0018; n_wdata_a = 32'hFFFFFFAB; n_wpar_a = 4'hF; n_be_a = 4'h1;
    step();
    n_ren_a = 1; n_addr_a = 15'h001F;
    n_ren_b = 1; n_addr_b = 15'h0000;
    push(2, "w9_read9", {4'h1, 32'h000000AB});
    push(3, "w9_read36", {4'h8, 32'hAB000000});
    step();

    // width-18 write into upper half of word 2
    n_wen_b = 1; n_addr_b = 15'h0050; n_wdata_b = 32'hFFFFC3D4; n_wpar_b = 4'b1110; n_be_b = 4'b0011;
    step();
    n_ren_b = 1; n_addr_b = 15'h0040;
    n_ren_a = 1; n_addr_a = 15'h0050;
    push(3, "w18_read36", {4'h8, 32'hC3D40000});
    push(2, "w18_read9", {4'h0, 32'h000000D4});
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
